// File: rtl/csr_exc_rpt.sv
// Host-side exception reporter: round-robin scan of per-thread exception CSRs,
// one record per thread over valid/ready, clear pulse back, plus a status read port.
module csr_exc_rpt #(
   parameter int NUM_TRD  = 8,
   parameter int CODE_W   = 4,
   parameter int CLR_WAIT = 1,
   localparam int TRD_W   = $clog2(NUM_TRD)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      rpt_en,
   input  logic [NUM_TRD-1:0]        exc_pend,
   input  logic [NUM_TRD*CODE_W-1:0] exc_code,
   input  logic [NUM_TRD-1:0]        valid_trd,
   input  logic [NUM_TRD-1:0]        run_trd,
   output logic [NUM_TRD-1:0]        clr_ex,
   output logic                      rpt_valid,
   input  logic                      rpt_ready,
   output logic [TRD_W-1:0]          rpt_trd,
   output logic [CODE_W-1:0]         rpt_code,
   output logic                      irq,
   input  logic                      rd_en,
   input  logic [TRD_W-1:0]          rd_trd,
   output logic                      rd_vld,
   output logic [CODE_W+2:0]         rd_data
);

   localparam int CNT_W = $clog2(CLR_WAIT + 1);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_REPORT = 2'd1;
   localparam logic [1:0] ST_CLEAR  = 2'd2;
   localparam logic [1:0] ST_WAIT   = 2'd3;

   logic [1:0]         state_reg, state_next;
   logic [TRD_W-1:0]   ptr_reg, ptr_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next;
   logic [NUM_TRD-1:0] clr_reg, clr_next;
   logic               valid_reg, valid_next;
   logic [TRD_W-1:0]   trd_reg, trd_next;
   logic [CODE_W-1:0]  code_reg, code_next;
   logic               rd_vld_reg;
   logic [CODE_W+2:0]  rd_data_reg;

   logic [CODE_W-1:0]  code_arr [NUM_TRD];
   logic [NUM_TRD-1:0] clr_onehot;
   logic               sel_found;
   logic [TRD_W-1:0]   sel_trd;
   logic [TRD_W-1:0]   scan_idx;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TRD; gi++) begin : g_trd
         assign code_arr[gi]   = exc_code[gi*CODE_W +: CODE_W];
         assign clr_onehot[gi] = (trd_reg == TRD_W'(gi));
      end
   endgenerate

   // Walk offsets from the far end so the smallest offset from ptr wins.
   always_comb begin
      sel_found = 1'b0;
      sel_trd   = '0;
      scan_idx  = '0;
      for (int i = NUM_TRD - 1; i >= 0; i--) begin
         scan_idx = ptr_reg + TRD_W'(i);
         if (exc_pend[scan_idx]) begin
            sel_found = 1'b1;
            sel_trd   = scan_idx;
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      ptr_next   = ptr_reg;
      cnt_next   = cnt_reg;
      clr_next   = '0;
      valid_next = valid_reg;
      trd_next   = trd_reg;
      code_next  = code_reg;
      case (state_reg)
         ST_IDLE: begin
            if (rpt_en && sel_found) begin
               state_next = ST_REPORT;
               valid_next = 1'b1;
               trd_next   = sel_trd;
               code_next  = code_arr[sel_trd];
            end
         end
         ST_REPORT: begin
            if (rpt_ready) begin
               valid_next = 1'b0;
               clr_next   = clr_onehot;
               ptr_next   = trd_reg + TRD_W'(1);
               state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            cnt_next   = CNT_W'(CLR_WAIT);
            state_next = ST_WAIT;
         end
         ST_WAIT: begin
            // Pending bits are ignored here so a not-yet-cleared bit is not reported twice.
            if (cnt_reg <= CNT_W'(1)) begin
               cnt_next   = '0;
               state_next = ST_IDLE;
            end else begin
               cnt_next = cnt_reg - CNT_W'(1);
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         ptr_reg   <= '0;
         cnt_reg   <= '0;
         clr_reg   <= '0;
         valid_reg <= 1'b0;
         trd_reg   <= '0;
         code_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ptr_reg   <= ptr_next;
         cnt_reg   <= cnt_next;
         clr_reg   <= clr_next;
         valid_reg <= valid_next;
         trd_reg   <= trd_next;
         code_reg  <= code_next;
      end
   end

   // Status read port runs beside the FSM and never touches the CSRs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rd_vld_reg  <= 1'b0;
         rd_data_reg <= '0;
      end else begin
         rd_vld_reg <= rd_en;
         if (rd_en) begin
            rd_data_reg <= {run_trd[rd_trd], valid_trd[rd_trd], exc_pend[rd_trd], code_arr[rd_trd]};
         end
      end
   end

   assign clr_ex    = clr_reg;
   assign rpt_valid = valid_reg;
   assign irq       = valid_reg;
   assign rpt_trd   = trd_reg;
   assign rpt_code  = code_reg;
   assign rd_vld    = rd_vld_reg;
   assign rd_data   = rd_data_reg;

endmodule

// File: tb/tb_csr_exc_rpt.sv
// Bench for csr_exc_rpt: sticky-CSR model, record/read scoreboards, read-port vector table.
module tb_csr_exc_rpt;

   localparam int NUM_TRD  = 8;
   localparam int CODE_W   = 4;
   localparam int CLR_WAIT = 1;
   localparam int TRD_W    = 3;

   logic                      clk = 1'b0;
   logic                      rst_n, rpt_en, rpt_ready, rd_en;
   logic [NUM_TRD-1:0]        exc_pend, valid_trd, run_trd, clr_ex;
   logic [NUM_TRD*CODE_W-1:0] exc_code;
   logic                      rpt_valid, irq, rd_vld;
   logic [TRD_W-1:0]          rpt_trd, rd_trd;
   logic [CODE_W-1:0]         rpt_code;
   logic [CODE_W+2:0]         rd_data;

   typedef struct packed {
      logic [TRD_W-1:0]  trd;
      logic [CODE_W-1:0] code;
   } rec_t;

   typedef struct {
      logic [TRD_W-1:0]   trd;
      logic [NUM_TRD-1:0] vld;
      logic [NUM_TRD-1:0] run;
      logic [NUM_TRD-1:0] pend;
      logic [CODE_W-1:0]  code;
      logic [CODE_W+2:0]  exp;
   } rd_vec_t;

   rec_t              rep_q [$];
   logic [CODE_W+2:0] rd_q  [$];
   rd_vec_t           rd_tab [6];

   logic [NUM_TRD-1:0] pend_model, clr_dly;
   logic [CODE_W-1:0]  code_arr [NUM_TRD];
   int checks, errors, cyc_cnt, last_acc, last_gap;

   bit               acc_seen, hold_q, rd_en_q;
   logic [TRD_W-1:0] acc_trd, prev_trd;
   logic [CODE_W-1:0] acc_code, prev_code;

   assign exc_pend = pend_model;
   always_comb begin
      exc_code = '0;
      for (int t = 0; t < NUM_TRD; t++) exc_code[t*CODE_W +: CODE_W] = code_arr[t];
   end

   csr_exc_rpt #(.NUM_TRD(NUM_TRD), .CODE_W(CODE_W), .CLR_WAIT(CLR_WAIT)) dut (
      .clk(clk), .rst_n(rst_n), .rpt_en(rpt_en), .exc_pend(exc_pend), .exc_code(exc_code),
      .valid_trd(valid_trd), .run_trd(run_trd), .clr_ex(clr_ex), .rpt_valid(rpt_valid),
      .rpt_ready(rpt_ready), .rpt_trd(rpt_trd), .rpt_code(rpt_code), .irq(irq),
      .rd_en(rd_en), .rd_trd(rd_trd), .rd_vld(rd_vld), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   // Capture handshake/request state exactly as the DUT sees it at each edge.
   always @(posedge clk) begin
      acc_seen  <= rst_n && rpt_valid && rpt_ready;
      acc_trd   <= rpt_trd;
      acc_code  <= rpt_code;
      hold_q    <= rst_n && rpt_valid && !rpt_ready;
      prev_trd  <= rpt_trd;
      prev_code <= rpt_code;
      rd_en_q   <= rst_n && rd_en;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // One clock: sample on the falling edge, score, then advance the CSR model.
   task automatic cyc();
      rec_t              r;
      logic [CODE_W+2:0] e;
      logic [NUM_TRD-1:0] exp_clr;
      @(negedge clk);
      cyc_cnt++;
      exp_clr = acc_seen ? (NUM_TRD'(1) << acc_trd) : '0;
      chk("clr_ex", 32'(clr_ex), 32'(exp_clr));
      chk("irq", 32'(irq), 32'(rpt_valid));
      if (acc_seen) begin
         if (rep_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rpt_unexpected actual=trd%0d/code%0h required=no record", acc_trd, acc_code);
         end else begin
            r = rep_q.pop_front();
            chk("rpt_trd", 32'(acc_trd), 32'(r.trd));
            chk("rpt_code", 32'(acc_code), 32'(r.code));
         end
         last_gap = cyc_cnt - last_acc;
         last_acc = cyc_cnt;
      end
      if (hold_q) begin
         chk("hold_valid", 32'(rpt_valid), 32'd1);
         chk("hold_trd", 32'(rpt_trd), 32'(prev_trd));
         chk("hold_code", 32'(rpt_code), 32'(prev_code));
      end
      chk("rd_vld", 32'(rd_vld), 32'(rd_en_q));
      if (rd_en_q) begin
         if (rd_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rd_unexpected actual=%0h required=no read", rd_data);
         end else begin
            e = rd_q.pop_front();
            chk("rd_data", 32'(rd_data), 32'(e));
         end
      end
      pend_model = pend_model & ~clr_dly;
      clr_dly    = clr_ex;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (rep_q.size() != 0 && n < 80) begin
         cyc();
         n++;
      end
      checks++;
      if (rep_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout actual=%0d records outstanding required=0", name, rep_q.size());
         rep_q.delete();
      end
   endtask

   task automatic idle_chk(input string name, input int n);
      for (int k = 0; k < n; k++) begin
         cyc();
         chk(name, 32'(rpt_valid), 32'd0);
      end
   endtask

   initial begin
      checks = 0; errors = 0; cyc_cnt = 0; last_acc = 0; last_gap = 0;
      rst_n = 1'b0; rpt_en = 1'b0; rpt_ready = 1'b0; rd_en = 1'b0; rd_trd = '0;
      valid_trd = '0; run_trd = '0; pend_model = '0; clr_dly = '0;
      for (int t = 0; t < NUM_TRD; t++) code_arr[t] = '0;

      rd_tab[0] = '{3'd5, 8'h20, 8'h20, 8'h20, 4'b1000, 7'h78};
      rd_tab[1] = '{3'd2, 8'h20, 8'h20, 8'h20, 4'b0000, 7'h00};
      rd_tab[2] = '{3'd2, 8'h04, 8'h00, 8'h04, 4'b0011, 7'h33};
      rd_tab[3] = '{3'd7, 8'h80, 8'h80, 8'h00, 4'b0101, 7'h65};
      rd_tab[4] = '{3'd0, 8'hFE, 8'hFE, 8'hFE, 4'b1010, 7'h0A};
      rd_tab[5] = '{3'd0, 8'h01, 8'h00, 8'h00, 4'b0110, 7'h26};

      repeat (3) cyc();
      chk("rst_rpt_valid", 32'(rpt_valid), 32'd0);
      chk("rst_rpt_trd", 32'(rpt_trd), 32'd0);
      chk("rst_rpt_code", 32'(rpt_code), 32'd0);
      chk("rst_clr_ex", 32'(clr_ex), 32'd0);
      chk("rst_rd_vld", 32'(rd_vld), 32'd0);
      chk("rst_rd_data", 32'(rd_data), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      rst_n = 1'b1; rpt_en = 1'b1; rpt_ready = 1'b1;
      cyc();

      // Single exception on thread 3.
      code_arr[3] = 4'b0100;
      pend_model  = 8'h08;
      rep_q.push_back('{3'd3, 4'b0100});
      cyc();
      chk("single_valid", 32'(rpt_valid), 32'd1);
      chk("single_trd", 32'(rpt_trd), 32'd3);
      chk("single_code", 32'(rpt_code), 32'b0100);
      cyc();
      chk("single_clr", 32'(clr_ex), 32'h08);
      chk("single_drop", 32'(rpt_valid), 32'd0);
      drain("single");
      idle_chk("single_no_dup", 6);

      // ptr is 4 now: thread 5 must come before thread 1.
      code_arr[5] = 4'b0111;
      code_arr[1] = 4'b1001;
      pend_model  = 8'h22;
      rep_q.push_back('{3'd5, 4'b0111});
      rep_q.push_back('{3'd1, 4'b1001});
      drain("ptr_order");
      idle_chk("ptr_no_dup", 6);

      // Backpressure with the code changing under a held record.
      rpt_ready   = 1'b0;
      code_arr[0] = 4'b0001;
      pend_model  = 8'h01;
      rep_q.push_back('{3'd0, 4'b0001});
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (i == 4) code_arr[0] = 4'b1110;
      end
      chk("bp_valid", 32'(rpt_valid), 32'd1);
      chk("bp_trd", 32'(rpt_trd), 32'd0);
      chk("bp_code", 32'(rpt_code), 32'b0001);
      rpt_ready = 1'b1;
      drain("backpressure");
      idle_chk("bp_no_dup", 6);

      // Status read table, back-to-back reads, FSM held off.
      rpt_en = 1'b0;
      for (int i = 0; i < 6; i++) begin
         valid_trd  = rd_tab[i].vld;
         run_trd    = rd_tab[i].run;
         pend_model = rd_tab[i].pend;
         for (int t = 0; t < NUM_TRD; t++)
            code_arr[t] = (t == int'(rd_tab[i].trd)) ? rd_tab[i].code : ~rd_tab[i].code;
         rd_trd = rd_tab[i].trd;
         rd_en  = 1'b1;
         rd_q.push_back(rd_tab[i].exp);
         cyc();
      end
      rd_en = 1'b0;
      cyc();
      cyc();
      chk("rd_hold_data", 32'(rd_data), 32'h26);
      chk("rd_idle_vld", 32'(rd_vld), 32'd0);
      valid_trd = '0;
      run_trd   = '0;

      // rpt_en gating: everything pending, nothing reported.
      pend_model = 8'hFF;
      for (int t = 0; t < NUM_TRD; t++) code_arr[t] = 4'(t + 3);
      for (int k = 0; k < 20; k++) begin
         cyc();
         chk("gated_irq", 32'(irq), 32'd0);
      end
      rpt_ready = 1'b0;
      rpt_en    = 1'b1;
      cyc();
      chk("en_valid", 32'(rpt_valid), 32'd1);
      chk("en_trd", 32'(rpt_trd), 32'd1);
      chk("en_code", 32'(rpt_code), 32'd4);
      cyc();
      cyc();

      // Reset while a record is held: dropped, no clear, ptr back to 0.
      rst_n = 1'b0;
      cyc();
      chk("mid_rst_valid", 32'(rpt_valid), 32'd0);
      chk("mid_rst_clr", 32'(clr_ex), 32'd0);
      chk("mid_rst_irq", 32'(irq), 32'd0);
      pend_model  = 8'h81;
      code_arr[0] = 4'b0010;
      code_arr[7] = 4'b1101;
      rpt_ready   = 1'b1;
      rep_q.push_back('{3'd0, 4'b0010});
      rep_q.push_back('{3'd7, 4'b1101});
      rst_n = 1'b1;
      drain("wrap");
      chk("b2b_gap", 32'(last_gap), 32'(3 + CLR_WAIT));
      idle_chk("wrap_no_dup", 6);

      // Re-raise both: ptr wrapped to 0, so thread 0 leads again.
      code_arr[0] = 4'b0101;
      code_arr[7] = 4'b0110;
      pend_model  = 8'h81;
      rep_q.push_back('{3'd0, 4'b0101});
      rep_q.push_back('{3'd7, 4'b0110});
      drain("rewrap");
      idle_chk("rewrap_no_dup", 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/csr_exc_rpt.md
Name: csr_exc_rpt

Overview:
- Host-side reader of the per-thread exception CSRs that the CSR controller populates.
- Round-robin scans the 8 thread CSRs for pending exceptions and latches one exception record per thread.
- Delivers each record to the host over a valid/ready channel, then pulses a per-thread clear back into the CSRs.
- Also provides a 1-cycle-latency random-access status read port for host polling.

Parameters:
- NUM_TRD, 8, number of hardware threads (power of two; TRD_W = log2(NUM_TRD)).
- CODE_W, 4, exception code width per thread.
- CLR_WAIT, 1, cycles to wait after a clear before rescanning (CSR update latency, ≥1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- rpt_en  in  1  enable new scans; when low, an in-flight report still completes
- exc_pend  in  NUM_TRD  per-thread sticky exception-pending bit from the CSRs
- exc_code  in  NUM_TRD*CODE_W  per-thread code, thread t at [t*CODE_W +: CODE_W]; bit0 seg fault, bit1 invalid op, bit2 alu exception, bit3 breakpoint
- valid_trd  in  NUM_TRD  thread allocated
- run_trd  in  NUM_TRD  thread running
- clr_ex  out  NUM_TRD  one-hot 1-cycle clear pulse to the thread CSR
- rpt_valid  out  1  exception record valid
- rpt_ready  in  1  host accepts record
- rpt_trd  out  TRD_W  thread of the record
- rpt_code  out  CODE_W  captured exception code
- irq  out  1  equals rpt_valid
- rd_en  in  1  status read request
- rd_trd  in  TRD_W  thread to read
- rd_vld  out  1  read data valid, 1 cycle after rd_en
- rd_data  out  CODE_W+3  {run_trd[t], valid_trd[t], exc_pend[t], exc_code[t]}

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE, ptr=0, wait counter=0, clr_ex=0, rpt_valid=0, rpt_trd=0, rpt_code=0, rd_vld=0, rd_data=0.
- Reset dominates any state; a record held mid-handshake is dropped and no clear is issued.
- FSM states:
  - IDLE: if rpt_en and |exc_pend, select thread s = first pending at index ≥ ptr, wrapping modulo NUM_TRD. Latch rpt_trd=s and rpt_code=exc_code[s]; go to REPORT. Selection is combinational from the current exc_pend, so rpt_valid rises 1 cycle after the pending bit is seen in IDLE.
  - REPORT: rpt_valid=1. rpt_trd and rpt_code are held stable while rpt_valid && !rpt_ready, regardless of exc_pend, exc_code or rpt_en changes. On rpt_valid && rpt_ready: next cycle rpt_valid=0, clr_ex[rpt_trd]=1 for exactly 1 cycle, ptr=rpt_trd+1 (wraps), go to CLEAR.
  - CLEAR: load wait counter = CLR_WAIT; go to WAIT.
  - WAIT: decrement the counter; at 0 go to IDLE. exc_pend is ignored while in CLEAR/WAIT, which prevents reporting a stale pending bit twice.
- The ready handshake is non-speculative: rpt_valid never drops without acceptance.
- rpt_ready asserted while rpt_valid=0 is ignored.
- Back-to-back: minimum spacing between two accepted records is 3+CLR_WAIT cycles.
- Fairness: after reporting thread t, thread t is considered last in the next scan.
- New exception on the same thread during REPORT/CLEAR/WAIT: exc_pend is sticky in the CSR. If it re-asserts after the clear has taken effect, it is reported on a later scan.
- rpt_en low in IDLE: stay in IDLE, irq=0. Pending exceptions are retained upstream.
- Status read port:
  - rd_en=1 in cycle n → rd_vld=1 in cycle n+1 with rd_data sampled at cycle n. rd_vld=0 otherwise; rd_data holds its last value.
  - Back-to-back reads are allowed every cycle.
  - The read port is independent of the FSM and never issues clears.
- rd_trd ≥ NUM_TRD is impossible for power-of-two NUM_TRD; no check is required.

Test Plan:
- Single exception: reset; exc_pend=8'h08, code[3]=4'b0100, rpt_ready=1 → rpt_valid 1 cycle after IDLE sample with rpt_trd=3, rpt_code=4'b0100; next cycle clr_ex=8'h08 for 1 cycle; ptr=4.
- Backpressure: exc_pend=8'h01, rpt_ready=0 for 10 cycles; change exc_code[0] mid-hold → rpt_trd=0 and rpt_code stay at the initial value; no clr_ex until ready=1, then exactly one pulse 8'h01.
- Round-robin wrap: exc_pend=8'h81, ptr=0, always-ready, model clears pending 1 cycle after clr_ex → report order thread 0 then 7. Re-raise thread 0 with 8'h81 → next report is thread 0 (ptr wrapped to 0).
- Stale suppression: exc_pend is not cleared by the model until 1 cycle after clr_ex → thread reported exactly once; with CLR_WAIT=1 no duplicate rpt_valid.
- rpt_en gating and reset mid-operation: rpt_en=0 with exc_pend=8'hFF → irq=0 for 20 cycles. Set rpt_en=1, hold rpt_ready=0, then assert rst_n=0 for 1 cycle → rpt_valid=0 and clr_ex=0 on the next cycle, ptr=0.
- Status read: valid_trd=8'h20, run_trd=8'h20, exc_pend[5]=1, code[5]=4'b1000; rd_en=1, rd_trd=5 → next cycle rd_vld=1, rd_data=7'b111_1000. Reads on consecutive cycles for threads 5 then 2 → rd_vld stays high 2 cycles with matching data.
